// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexes an 8-digit hex word onto a common-anode
// seven-segment display. Content is captured once per frame so updates never
// tear. Each digit slot starts with a blanking gap to hide ghosting.
module seg_scan_driver #(
  parameter int          DIV     = 100000,
  parameter int          BLANK   = 16,
  parameter logic [7:0]  DP_MASK = 8'h10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] display,
  input  logic [7:0]  displayEnable,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frameStart
);

  localparam int                CNT_W   = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DIV - 1);

  // Active-low hex decode, bit order g,f,e,d,c,b,a.
  function automatic logic [6:0] hex7(input logic [3:0] h);
    logic [6:0] s;
    s = 7'h7F;
    case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  logic [2:0]       digit_p0;
  logic [CNT_W-1:0] cnt_p0;
  logic             first_p0;
  logic [31:0]      shadow_disp_p0;
  logic [7:0]       shadow_en_p0;

  logic             slot_end_p0;
  logic             frame_end_p0;
  logic             blank_p0;
  logic [3:0]       nibble_p0;

  logic [7:0]       an_p1;
  logic [6:0]       seg_p1;
  logic             dp_p1;
  logic             fs_p1;

  // ---- stage p0: scan counters and frame snapshot ----

  // Decode of the current scan position.
  always_comb begin
    slot_end_p0  = (cnt_p0 == CNT_MAX);
    frame_end_p0 = slot_end_p0 && (digit_p0 == 3'd7);
    blank_p0     = (int'(cnt_p0) < BLANK) || !shadow_en_p0[digit_p0];
    nibble_p0    = shadow_disp_p0[{digit_p0, 2'b00} +: 4];
  end

  // Slot cycle counter and digit index; digit wraps 7 -> 0 naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p0   <= '0;
      digit_p0 <= 3'd0;
      first_p0 <= 1'b1;
    end else begin
      first_p0 <= 1'b0;
      if (slot_end_p0) begin
        cnt_p0   <= '0;
        digit_p0 <= digit_p0 + 3'd1;
      end else begin
        cnt_p0   <= cnt_p0 + CNT_W'(1);
      end
    end
  end

  // Shadow capture at frame end, or immediately after reset via first_p0.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_disp_p0 <= '0;
      shadow_en_p0   <= '0;
    end else if (first_p0 || frame_end_p0) begin
      shadow_disp_p0 <= display;
      shadow_en_p0   <= displayEnable;
    end
  end

  // ---- stage p1: registered display drive ----

  // Outputs reflect the previous cycle's scan position and shadow content.
  always_ff @(posedge clk) begin
    if (rst) begin
      an_p1  <= 8'hFF;
      seg_p1 <= 7'h7F;
      dp_p1  <= 1'b1;
      fs_p1  <= 1'b0;
    end else begin
      fs_p1 <= (digit_p0 == 3'd0) && (cnt_p0 == '0);
      if (blank_p0) begin
        an_p1  <= 8'hFF;
        seg_p1 <= 7'h7F;
        dp_p1  <= 1'b1;
      end else begin
        an_p1  <= ~(8'h01 << digit_p0);
        seg_p1 <= hex7(nibble_p0);
        dp_p1  <= ~DP_MASK[digit_p0];
      end
    end
  end

  assign an         = an_p1;
  assign seg        = seg_p1;
  assign dp         = dp_p1;
  assign frameStart = fs_p1;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: one instance with DIV=8/BLANK=2 and one
// with DIV=4/BLANK=0, driven from shared clock, reset and display inputs.
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] display;
  logic [7:0]  en;

  logic [7:0]  an_a, an_b;
  logic [6:0]  seg_a, seg_b;
  logic        dp_a, dp_b, fs_a, fs_b;

  int nvec  = 0;
  int nfail = 0;
  int pos   = 0;

  always #5 clk = ~clk;

  seg_scan_driver #(.DIV(8), .BLANK(2), .DP_MASK(8'h10)) dut_a (
    .clk(clk), .rst(rst), .display(display), .displayEnable(en),
    .an(an_a), .seg(seg_a), .dp(dp_a), .frameStart(fs_a)
  );

  seg_scan_driver #(.DIV(4), .BLANK(0), .DP_MASK(8'h10)) dut_b (
    .clk(clk), .rst(rst), .display(display), .displayEnable(en),
    .an(an_b), .seg(seg_b), .dp(dp_b), .frameStart(fs_b)
  );

  typedef struct {
    int          phase;
    int          off;
    logic [31:0] disp;
    logic [7:0]  en;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
  } vec_t;

  vec_t vq[$];

  task automatic add(input int ph, input int off, input logic [31:0] d,
                     input logic [7:0] e, input logic [7:0] a,
                     input logic [6:0] s, input logic p);
    vec_t v;
    v.phase = ph; v.off = off; v.disp = d; v.en = e;
    v.an = a; v.seg = s; v.dp = p;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Advance at least one cycle, then until the chosen frameStart is seen.
  task automatic wait_fs(input bit use_b, output int n);
    logic hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < 200) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      hit = use_b ? fs_b : fs_a;
    end
    check(use_b ? "fs_b wait" : "fs_a wait", 32'(hit), 32'd1);
  endtask

  initial begin
    int n;
    int cur_phase;

    // Phase 1: display 89ABCDEF, all digits enabled, DIV=8, BLANK=2.
    add(1,  0, 32'h89ABCDEF, 8'hFF, 8'hFF, 7'h7F, 1'b1);
    add(1,  1, 32'h89ABCDEF, 8'hFF, 8'hFF, 7'h7F, 1'b1);
    add(1,  2, 32'h89ABCDEF, 8'hFF, 8'hFE, 7'h0E, 1'b1);
    add(1,  7, 32'h89ABCDEF, 8'hFF, 8'hFE, 7'h0E, 1'b1);
    add(1,  8, 32'h89ABCDEF, 8'hFF, 8'hFF, 7'h7F, 1'b1);
    add(1, 10, 32'h89ABCDEF, 8'hFF, 8'hFD, 7'h06, 1'b1);
    add(1, 26, 32'h89ABCDEF, 8'hFF, 8'hF7, 7'h46, 1'b1);
    add(1, 33, 32'h89ABCDEF, 8'hFF, 8'hFF, 7'h7F, 1'b1);
    add(1, 34, 32'h89ABCDEF, 8'hFF, 8'hEF, 7'h03, 1'b0);
    add(1, 39, 32'h89ABCDEF, 8'hFF, 8'hEF, 7'h03, 1'b0);
    add(1, 42, 32'h89ABCDEF, 8'hFF, 8'hDF, 7'h08, 1'b1);
    add(1, 50, 32'h89ABCDEF, 8'hFF, 8'hBF, 7'h10, 1'b1);
    add(1, 58, 32'h89ABCDEF, 8'hFF, 8'h7F, 7'h00, 1'b1);
    add(1, 63, 32'h89ABCDEF, 8'hFF, 8'h7F, 7'h00, 1'b1);
    // Phase 2: enable mask 13 lights digits 0, 1, 4 only.
    add(2,  2, 32'h89ABCDEF, 8'h13, 8'hFE, 7'h0E, 1'b1);
    add(2, 10, 32'h89ABCDEF, 8'h13, 8'hFD, 7'h06, 1'b1);
    add(2, 18, 32'h89ABCDEF, 8'h13, 8'hFF, 7'h7F, 1'b1);
    add(2, 26, 32'h89ABCDEF, 8'h13, 8'hFF, 7'h7F, 1'b1);
    add(2, 34, 32'h89ABCDEF, 8'h13, 8'hEF, 7'h03, 1'b0);
    add(2, 36, 32'h89ABCDEF, 8'h13, 8'hEF, 7'h03, 1'b0);
    add(2, 42, 32'h89ABCDEF, 8'h13, 8'hFF, 7'h7F, 1'b1);
    add(2, 50, 32'h89ABCDEF, 8'h13, 8'hFF, 7'h7F, 1'b1);
    add(2, 58, 32'h89ABCDEF, 8'h13, 8'hFF, 7'h7F, 1'b1);
    add(2, 63, 32'h89ABCDEF, 8'h13, 8'hFF, 7'h7F, 1'b1);

    // Reset held three cycles with all-F content.
    rst = 1'b1;
    display = 32'hFFFFFFFF;
    en = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("rst%0d an", i),  32'(an_a),  32'hFF);
      check($sformatf("rst%0d seg", i), 32'(seg_a), 32'h7F);
      check($sformatf("rst%0d dp", i),  32'(dp_a),  32'd1);
      check($sformatf("rst%0d fs", i),  32'(fs_a),  32'd0);
    end
    rst = 1'b0;
    step(1);
    check("post-rst fs_a", 32'(fs_a), 32'd1);
    check("post-rst fs_b", 32'(fs_b), 32'd1);
    check("post-rst an_a blank", 32'(an_a), 32'hFF);
    check("post-rst an_b blank", 32'(an_b), 32'hFF);
    step(1);
    check("c1 fs_a low", 32'(fs_a), 32'd0);
    check("c1 an_a blank", 32'(an_a), 32'hFF);
    check("c1 an_b lit", 32'(an_b), 32'hFE);
    check("c1 seg_b F", 32'(seg_b), 32'h0E);
    step(1);
    check("c2 an_a lit", 32'(an_a), 32'hFE);
    check("c2 seg_a F", 32'(seg_a), 32'h0E);

    // Table-driven frame checks on instance A.
    cur_phase = -1;
    foreach (vq[i]) begin
      if (vq[i].phase != cur_phase) begin
        display = vq[i].disp;
        en = vq[i].en;
        wait_fs(1'b0, n);
        wait_fs(1'b0, n);
        pos = 0;
        cur_phase = vq[i].phase;
      end
      step(vq[i].off - pos);
      pos = vq[i].off;
      check($sformatf("v%0d an", i),  32'(an_a),  32'(vq[i].an));
      check($sformatf("v%0d seg", i), 32'(seg_a), 32'(vq[i].seg));
      check($sformatf("v%0d dp", i),  32'(dp_a),  32'(vq[i].dp));
    end

    // No tearing: content change in slot 3 waits for the next frame.
    display = 32'h00000000;
    en = 8'hFF;
    wait_fs(1'b0, n);
    wait_fs(1'b0, n);
    step(26);
    check("tear s3 an", 32'(an_a), 32'hF7);
    check("tear s3 seg", 32'(seg_a), 32'h40);
    display = 32'h12345678;
    step(8);
    check("tear s4 an", 32'(an_a), 32'hEF);
    check("tear s4 seg", 32'(seg_a), 32'h40);
    check("tear s4 dp", 32'(dp_a), 32'd0);
    step(24);
    check("tear s7 seg", 32'(seg_a), 32'h40);
    wait_fs(1'b0, n);
    check("tear fs gap", 32'(n), 32'd6);
    step(2);
    check("new s0 an", 32'(an_a), 32'hFE);
    check("new s0 seg", 32'(seg_a), 32'h00);
    step(8);
    check("new s1 seg", 32'(seg_a), 32'h78);
    step(48);
    check("new s7 seg", 32'(seg_a), 32'h79);

    // Reset in slot 5, then the scan restarts at slot 0.
    wait_fs(1'b0, n);
    step(42);
    check("pre-rst an s5", 32'(an_a), 32'hDF);
    rst = 1'b1;
    step(1);
    check("midrst an", 32'(an_a), 32'hFF);
    check("midrst seg", 32'(seg_a), 32'h7F);
    check("midrst dp", 32'(dp_a), 32'd1);
    check("midrst fs", 32'(fs_a), 32'd0);
    rst = 1'b0;
    wait_fs(1'b0, n);
    check("midrst first fs delay", 32'(n), 32'd1);
    step(2);
    check("resume s0 an", 32'(an_a), 32'hFE);
    check("resume s0 seg", 32'(seg_a), 32'h00);
    wait_fs(1'b0, n);
    check("fs period", 32'(n + 2), 32'd64);

    // BLANK=0 instance: contiguous, exclusive anode scan.
    wait_fs(1'b1, n);
    check("b s0 seg", 32'(seg_b), 32'h00);
    for (int k = 0; k < 64; k++) begin
      logic [7:0] exp_an;
      exp_an = ~(8'h01 << ((k / 4) % 8));
      check($sformatf("b an k%0d", k), 32'(an_b), 32'(exp_an));
      if (k == 16) check("b s4 dp", 32'(dp_b), 32'd0);
      step(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
